// File: rtl/im_pkg.sv
// Shared types and constants for the instruction-fetch responder.
//   im_state_e     : responder FSM states (IDLE / WAIT / RESP)
//   INSTR_W        : instruction width
//   LAT_CNT_W      : latency down-counter width (LATENCY up to 15)
//   NOP_INSTR_DEF  : default filler instruction (addi x0,x0,0)
//   fetch_addr_bad : misaligned / out-of-range byte PC check
package im_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned LAT_CNT_W = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } im_state_e;

    // A byte PC is unusable if it is not word aligned or indexes past the array.
    function automatic logic fetch_addr_bad(input logic [31:0] addr, input int unsigned addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/im_sram_array.sv
// Instruction storage: DEPTH x 32-bit words.
//   clk      : rising-edge clock
//   rd_en    : capture mem[rd_addr] into rd_data at the edge (rd_data holds otherwise)
//   rd_addr  : word read index
//   rd_data  : registered read data
//   wr_en    : write wr_data to mem[wr_addr] at the edge
//   wr_addr  : word write index
//   wr_data  : write data
// A same-edge read and write of one word returns the old contents.
module im_sram_array
    import im_pkg::*;
#(
    parameter int unsigned DEPTH = 16384
) (
    input  logic                       clk,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [INSTR_W-1:0]         rd_data,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [INSTR_W-1:0]         wr_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port with output hold
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/im_fetch_responder.sv
// Responder end of the instruction-fetch interface. Accepts byte-PC fetch requests,
// reads the word-addressed instruction array and returns the instruction a fixed
// LATENCY cycles after acceptance. The response is held under IF stall and a pending
// fetch is dropped on flush.
//
// Parameters: DEPTH (power of 2), LATENCY (1..15), NOP_INSTR.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset
//   req_valid  : IF presents a fetch address
//   req_addr   : byte PC
//   req_ready  : request accepted when req_valid && req_ready (combinational)
//   flush      : redirect, kills any pending fetch, highest priority
//   rsp_valid  : response valid
//   rsp_ready  : IF consumes the response (low = stall)
//   rsp_instr  : fetched instruction (NOP_INSTR when no data response is held)
//   rsp_err    : misaligned or out-of-range fetch
// Optional build macro IM_BOOT_LOAD_EN adds load_we / load_addr / load_data for
// writing the array; while load_we is high the FSM is frozen and req_ready is low.
module im_fetch_responder
    import im_pkg::*;
#(
    parameter int unsigned        DEPTH     = 16384,
    parameter int unsigned        LATENCY   = 1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef IM_BOOT_LOAD_EN
    input  logic                      load_we,
    input  logic [$clog2(DEPTH)-1:0]  load_addr,
    input  logic [INSTR_W-1:0]        load_data,
`endif
    input  logic                      req_valid,
    input  logic [31:0]               req_addr,
    output logic                      req_ready,
    input  logic                      flush,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [INSTR_W-1:0]        rsp_instr,
    output logic                      rsp_err
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    im_state_e             state_q, state_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  err_q, err_d;
    logic                  rsp_valid_d;
    logic                  rsp_err_d;

    logic [ADDR_W-1:0]     req_idx;
    logic                  req_bad;
    logic                  accept;
    logic                  freeze;

    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [INSTR_W-1:0]    rd_data;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [INSTR_W-1:0]    wr_data;

`ifdef IM_BOOT_LOAD_EN
    assign freeze  = load_we;
    assign wr_en   = load_we;
    assign wr_addr = load_addr;
    assign wr_data = load_data;
`else
    assign freeze  = 1'b0;
    assign wr_en   = 1'b0;
    assign wr_addr = '0;
    assign wr_data = '0;
`endif

    // Request decode
    assign req_idx = req_addr[ADDR_W+1:2];
    assign req_bad = fetch_addr_bad(req_addr, ADDR_W);

    // Ready in IDLE, or in RESP when the held response is being consumed this cycle
    assign req_ready = rst && !flush && !freeze &&
                       ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    assign accept    = req_valid && req_ready;

    // Error responses and idle cycles present the filler instruction
    assign rsp_instr = (rsp_valid && !rsp_err) ? rd_data : NOP_INSTR;

    // Next-state / datapath control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid;
        rsp_err_d   = rsp_err;
        rd_en       = 1'b0;
        rd_addr     = addr_q;

        if (flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
        end else if (!freeze) begin
            unique case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
                        addr_d = req_idx;
                        err_d  = req_bad;
                        if (LATENCY == 1) begin
                            // Single-cycle latency reads the array straight from the request
                            state_d     = RESP;
                            cnt_d       = '0;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = req_bad;
                            rd_en       = !req_bad;
                            rd_addr     = req_idx;
                        end else begin
                            state_d     = WAIT;
                            cnt_d       = LAT_CNT_W'(LATENCY - 1);
                            rsp_valid_d = 1'b0;
                            rsp_err_d   = 1'b0;
                        end
                    end else if ((state_q == RESP) && rsp_ready) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b0;
                        rsp_err_d   = 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt_q == LAT_CNT_W'(1)) begin
                        state_d     = RESP;
                        cnt_d       = '0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = err_q;
                        rd_en       = !err_q;
                        rd_addr     = addr_q;
                    end else begin
                        cnt_d = cnt_q - LAT_CNT_W'(1);
                    end
                end
                default: begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
        end
    end

    im_sram_array #(
        .DEPTH (DEPTH)
    ) u_sram (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

endmodule
